// File: rtl/hc74_pkg.sv
// rtl/hc74_pkg.sv - shared types, constants and model encode function for the HC74 monitor
package hc74_pkg;

    // Depth of the synchronizer chain on every DUT-side pin.
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_COMPARE  = 2'd2,
        ST_WAIT     = 2'd3
    } mon_state_t;

    // Forced output pair {mQ, mQN} for the asynchronous preset/clear cases.
    // S=R=1 is not forcing; callers handle that case (hold or clock capture),
    // and the value returned for it is never used.
    function automatic logic [1:0] model_encode(input logic s, input logic r);
        logic [1:0] qq;
        case ({s, r})
            2'b00:   qq = 2'b11;
            2'b01:   qq = 2'b10;
            2'b10:   qq = 2'b01;
            default: qq = 2'b01;
        endcase
        return qq;
    endfunction

endpackage

// File: rtl/hc74_mon_ch.sv
// rtl/hc74_mon_ch.sv - one monitored HC74 channel: synchronizers, reference model, settle/compare FSM
// Ports:
//   clk, rst_n               system clock, asynchronous active-low reset
//   dut_clk, s, r, d, q, q_n raw DUT pins of this channel (s/r active-low)
//   mismatch                 high for the single COMPARE cycle that finds a difference
//   armed                    model is defined and compares are active
// Config macro: HC74_MON_COMPLEMENT_EN adds q_n to change detection and comparison.
module hc74_mon_ch
    import hc74_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dut_clk,
    input  logic s,
    input  logic r,
    input  logic d,
    input  logic q,
    input  logic q_n,
    output logic mismatch,
    output logic armed
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    // Bit positions inside the packed pin vector.
    localparam int B_CLK = 5;
    localparam int B_S   = 4;
    localparam int B_R   = 3;
    localparam int B_D   = 2;
    localparam int B_Q   = 1;
    localparam int B_QN  = 0;

`ifdef HC74_MON_COMPLEMENT_EN
    localparam logic [5:0] CHG_MASK = 6'b111111;
    localparam logic [1:0] CMP_MASK = 2'b11;
`else
    localparam logic [5:0] CHG_MASK = 6'b111110;
    localparam logic [1:0] CMP_MASK = 2'b10;
`endif

    logic [5:0]        pins;
    logic [5:0]        sync_pipe [SYNC_DEPTH];
    logic [5:0]        cur;
    logic [5:0]        prev;
    logic [SYNC_DEPTH:0] live_sr;
    logic              live;
    logic              rise;
    logic              changed;
    logic              arm_evt;
    logic              mq;
    logic              mqn;
    mon_state_t        state;
    logic [CNT_W-1:0]  cnt;

    assign pins = {dut_clk, s, r, d, q, q_n};
    assign cur  = sync_pipe[SYNC_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                sync_pipe[i] <= '0;
            end
            prev    <= '0;
            live_sr <= '0;
        end else begin
            sync_pipe[0] <= pins;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
            prev    <= cur;
            live_sr <= {live_sr[SYNC_DEPTH-1:0], 1'b1};
        end
    end

    // The synchronizers and the previous-value register come out of reset as
    // zeros, which would read as S=R=0 and fake edges. Nothing looks at them
    // until both the synced and previous values hold real pin data.
    assign live    = live_sr[SYNC_DEPTH];
    assign rise    = live & cur[B_CLK] & ~prev[B_CLK];
    assign changed = live & (|((cur ^ prev) & CHG_MASK));
    assign arm_evt = live & (~cur[B_S] | ~cur[B_R] | rise);

    // Reference model: preset/clear dominate; otherwise capture the D value
    // that was present the cycle before the edge was seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq  <= 1'b0;
            mqn <= 1'b1;
        end else if (live) begin
            if (!cur[B_S] || !cur[B_R]) begin
                {mq, mqn} <= model_encode(cur[B_S], cur[B_R]);
            end else if (rise) begin
                mq  <= prev[B_D];
                mqn <= ~prev[B_D];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_evt) begin
                        state <= ST_SETTLING;
                        cnt   <= '0;
                    end
                end
                ST_SETTLING: begin
                    if (changed) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_COMPARE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    // A change landing on the compare cycle opens a new window
                    // rather than being lost in WAIT.
                    state <= changed ? ST_SETTLING : ST_WAIT;
                    cnt   <= '0;
                end
                default: begin
                    if (changed) begin
                        state <= ST_SETTLING;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign mismatch = (state == ST_COMPARE) &&
                      (|(({cur[B_Q], cur[B_QN]} ^ {mq, mqn}) & CMP_MASK));
    assign armed    = (state != ST_IDLE);

endmodule

// File: rtl/hc74_monitor.sv
// rtl/hc74_monitor.sv - dual HC74 response checker: per-channel monitors plus sticky flags and saturating error count
// Ports:
//   Clk, Rst_N        system clock (>=4x any DUT clock), asynchronous active-low reset
//   Clr               synchronous clear of Err and Err_Cnt (wins over a same-cycle mismatch)
//   Dut_Clk,S,R,D     per-channel DUT stimulus pins (S/R active-low)
//   Q, Q_N            per-channel DUT outputs
//   Err               sticky per-channel mismatch flags
//   Err_Cnt           saturating count of mismatch events over all channels
//   Armed             per-channel model defined / compares active
// Config macro: HC74_MON_COMPLEMENT_EN enables checking of Q_N.
module hc74_monitor
    import hc74_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int ERR_W  = 8,
    parameter int SETTLE = 2
) (
    input  logic             Clk,
    input  logic             Rst_N,
    input  logic             Clr,
    input  logic [N_CH-1:0]  Dut_Clk,
    input  logic [N_CH-1:0]  S,
    input  logic [N_CH-1:0]  R,
    input  logic [N_CH-1:0]  D,
    input  logic [N_CH-1:0]  Q,
    input  logic [N_CH-1:0]  Q_N,
    output logic [N_CH-1:0]  Err,
    output logic [ERR_W-1:0] Err_Cnt,
    output logic [N_CH-1:0]  Armed
);

    localparam int SUM_W = ERR_W + $clog2(N_CH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_W{1'b1}});

    logic [N_CH-1:0]  mismatch;
    logic [SUM_W-1:0] mis_sum;
    logic [SUM_W-1:0] cnt_sum;
    logic [ERR_W-1:0] cnt_next;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        hc74_mon_ch #(
            .SETTLE (SETTLE)
        ) u_ch (
            .clk      (Clk),
            .rst_n    (Rst_N),
            .dut_clk  (Dut_Clk[ch]),
            .s        (S[ch]),
            .r        (R[ch]),
            .d        (D[ch]),
            .q        (Q[ch]),
            .q_n      (Q_N[ch]),
            .mismatch (mismatch[ch]),
            .armed    (Armed[ch])
        );
    end

    // Channels failing in the same cycle all count in that cycle.
    always_comb begin
        mis_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            mis_sum = mis_sum + SUM_W'(mismatch[i]);
        end
        cnt_sum  = SUM_W'(Err_Cnt) + mis_sum;
        cnt_next = (cnt_sum > CNT_MAX) ? {ERR_W{1'b1}} : cnt_sum[ERR_W-1:0];
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            Err     <= '0;
            Err_Cnt <= '0;
        end else if (Clr) begin
            Err     <= '0;
            Err_Cnt <= '0;
        end else begin
            Err     <= Err | mismatch;
            Err_Cnt <= cnt_next;
        end
    end

endmodule

// File: doc/hc74_monitor.md
# hc74_monitor

Synthesizable response checker for the dual HC74 D flip-flop. It samples each channel's DUT inputs and outputs on a fast system clock and runs a cycle-accurate reference model of a 74HC74 channel (active-low preset/clear, rising-edge D capture). Mismatches are flagged per channel and counted. It sits on the observation side of the HC74 bench, consuming what the stimulus drives, and can also be placed on-chip next to HC74 as a built-in self-check.

## Interface
Parameters:
- N_CH, 2, number of monitored flip-flop channels
- ERR_W, 8, width of the error counter
- SETTLE, 2, system-clock cycles inputs must be stable before outputs are compared (≥1)

Ports:
- Clk  in  1  system clock, at least 4× faster than any DUT clock
- Rst_N  in  1  asynchronous, active-low reset
- Clr  in  1  synchronous clear of Err and Err_Cnt
- Dut_Clk  in  N_CH  per-channel DUT clock, sampled as data
- S  in  N_CH  DUT preset, active-low
- R  in  N_CH  DUT clear, active-low
- D  in  N_CH  DUT data
- Q  in  N_CH  DUT output
- Q_N  in  N_CH  DUT complementary output
- Err  out  N_CH  sticky per-channel mismatch flag
- Err_Cnt  out  ERR_W  saturating count of mismatch events, all channels
- Armed  out  N_CH  channel model is defined and compares are active

## Operation
- All DUT-side inputs pass through 2-FF synchronizers. Edge detection and the model use synchronized values only.
- Model per channel, evaluated each Clk:
  - S=0, R=0: mQ=1, mQN=1.
  - S=0 only: mQ=1, mQN=0.
  - R=0 only: mQ=0, mQN=1.
  - S=R=1 and a rising edge on synced Dut_Clk: mQ=D, mQN=~D. D is the synced value from the cycle before the edge is detected.
  - Otherwise the model holds.
- Per-channel FSM:
  - IDLE: model undefined, no compares. Leave for SETTLING on the first S=0, R=0, or Dut_Clk rise; Armed goes to 1.
  - SETTLING: a counter counts stable cycles. Any change in synced S, R, D, Dut_Clk, Q or Q_N resets it to 0. At SETTLE, go to COMPARE.
  - COMPARE: one cycle. If Q≠mQ, or Q_N≠mQN (see Configuration), it is a mismatch. Then go to WAIT.
  - WAIT: no compares. Any synced input change returns the FSM to SETTLING.
- A mismatch sets Err[ch] (sticky) and increments Err_Cnt by one. Exactly one count is taken per COMPARE, never one per cycle.
- Several channels mismatching in the same cycle add their combined number to Err_Cnt in that cycle.
- Err_Cnt saturates at 2^ERR_W−1 and does not wrap.
- Clr zeroes Err and Err_Cnt. If Clr and a mismatch occur in the same cycle, Clr wins and both read 0 afterwards. Clr does not affect the model, the FSM or Armed.

## Timing
- Reset values: Err=0, Err_Cnt=0, Armed=0, FSM=IDLE, mQ=0, mQN=1, synchronizers 0.
- Latency from a DUT pin change to its synced value: 2 Clk.
- Synced edge to model update: 1 Clk.
- Last input change to COMPARE: SETTLE+1 Clk.
- COMPARE to Err/Err_Cnt visible: 1 Clk (registered outputs).
- Asynchronous reset in the middle of a window drops any pending compare. The channel returns to IDLE.
- A Dut_Clk edge with S=0 or R=0 active does not change the model.
- When S and R are released together, the model holds mQ=1, mQN=1 until the next Dut_Clk rise.

## Configuration
- HC74_MON_COMPLEMENT_EN:
  - Defined: Q_N is compared against mQN, which catches a stuck or shorted complement output.
  - Undefined: Q_N is ignored, only Q is compared, and Q_N is excluded from change detection.

## Structure
- Shared package hc74_pkg holds:
  - the FSM state enum (IDLE, SETTLING, COMPARE, WAIT);
  - the synchronizer depth constant (2);
  - the model encode function for (S, R) to (mQ, mQN).
- Sub-module hc74_mon_ch is instantiated N_CH times. Each instance contains the synchronizers, model, FSM and settle counter, and outputs mismatch and armed.
- The top level holds the Err register and the saturating adder for Err_Cnt.

## Test plan
- Reset, then S=R=1 and no Dut_Clk edges for 50 Clk -> Armed=0, Err=0, Err_Cnt=0.
- Correct DUT, D=1 and a Dut_Clk rise on channel 0 -> Armed[0]=1, Q=1 matches, Err=0 after SETTLE+4 Clk.
- Q stuck at 0 on channel 1, R released, D=1 and an edge -> Err[1]=1 and Err_Cnt=1 after exactly one COMPARE. A further 20 stable Clk leave it at 1.
- Both channels stuck, 300 toggling windows with ERR_W=8 -> Err_Cnt saturates at 255. Then Clr -> Err=0, Err_Cnt=0.
- S=R=0 with Q=Q_N=1 -> no error. With HC74_MON_COMPLEMENT_EN defined and Q_N forced 0 -> Err set. With the macro undefined -> no error.
- Rst_N asserted two cycles into SETTLING on a faulty channel -> no increment, Armed=0.
